mem_stage: RTL and testbench

Memory stage of the 5-stage WISC processor, directly downstream of `execute`. It takes the execute result (`Out`, used as the effective address or passed through as the ALU value) and the store data. For loads and stores it runs a request/wait handshake against a multi-cycle data memory and stalls the upstream pipeline until the access completes. It also flags misaligned accesses and captures `halt`.

---
 rtl/mem_stage_pkg.sv | 24 ++
 rtl/mem_req_fsm.sv | 79 +++++++
 rtl/mem_stage.sv | 123 ++++++++++++
 tb/tb_mem_stage.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// ---------------------------------------------------------------------------
// mem_stage_pkg
// Shared types and constants for the WISC memory stage.
//   state_t          : request FSM state encoding (IDLE/REQ/WAIT/DONE)
//   WAIT_MAX_DEFAULT : default number of WAIT cycles before a timeout error
//   is_misaligned()  : true when a 16-bit access address is odd
// ---------------------------------------------------------------------------
package mem_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int WAIT_MAX_DEFAULT = 15;

    // Word accesses must be on even byte addresses.
    function automatic logic is_misaligned(input logic [15:0] addr);
        return addr[0];
    endfunction

endpackage

// File: rtl/mem_req_fsm.sv
// ---------------------------------------------------------------------------
// mem_req_fsm
// Request/wait sequencer for the memory stage: state register, WAIT timeout
// counter, memory request strobes and the upstream stall.
//   clk, rst      : clock, synchronous active-high reset
//   start         : an aligned memory op is accepted this cycle (IDLE only)
//   op_write      : latched op type (1 = store, 0 = load)
//   mem_busy      : memory cannot take the request this cycle
//   mem_done      : memory access complete
//   state         : current FSM state
//   mem_rd/mem_wr : request strobes, high only in REQ
//   stall         : hold upstream (accept cycle through last WAIT cycle)
//   wait_done     : mem_done observed while in WAIT
//   wait_timeout  : last permitted WAIT cycle passed with no mem_done
// ---------------------------------------------------------------------------
module mem_req_fsm
    import mem_stage_pkg::*;
#(
    parameter int WAIT_MAX = WAIT_MAX_DEFAULT
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   start,
    input  logic   op_write,
    input  logic   mem_busy,
    input  logic   mem_done,
    output state_t state,
    output logic   mem_rd,
    output logic   mem_wr,
    output logic   stall,
    output logic   wait_done,
    output logic   wait_timeout
);

    localparam int CW = $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(WAIT_MAX);
    // The counter holds the number of WAIT cycles already completed, so the
    // cycle in which it would reach WAIT_MAX is the last one allowed.
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_MAX - 1);

    logic [CW-1:0] cnt;

    assign mem_rd       = (state == ST_REQ) && !op_write;
    assign mem_wr       = (state == ST_REQ) &&  op_write;
    assign stall        = start || (state == ST_REQ) || (state == ST_WAIT);
    assign wait_done    = (state == ST_WAIT) && mem_done;
    // mem_done in the final cycle takes priority over the timeout.
    assign wait_timeout = (state == ST_WAIT) && !mem_done && (cnt >= CNT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) state <= ST_REQ;
                end
                ST_REQ: begin
                    if (!mem_busy) begin
                        state <= ST_WAIT;
                        cnt   <= '0;
                    end
                end
                ST_WAIT: begin
                    if (cnt != CNT_MAX) cnt <= cnt + 1'b1;   // saturate, never wrap
                    if (wait_done || wait_timeout) state <= ST_DONE;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
// Memory stage of the 5-stage WISC pipeline. Passes non-memory results
// straight through, runs a request/wait handshake with a multi-cycle data
// memory for loads/stores (stalling upstream meanwhile), flags misaligned
// accesses, memory faults and timeouts in a sticky err, and latches HALT.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid            : instruction presented by execute
//   memRead/memWrite    : load / store
//   halt                : HALT instruction
//   exOut               : address (memory ops) or pass-through value
//   wrData              : store data
//   stall               : upstream must hold inputs
//   out_valid/out_data  : writeback result
//   err, halted         : sticky status flags (cleared by rst only)
//   mem_addr/mem_wdata  : memory address / write data
//   mem_rd/mem_wr       : memory request strobes
//   mem_busy, mem_done  : memory flow control / completion
//   mem_rdata, mem_err  : read data / fault, valid with mem_done
// ---------------------------------------------------------------------------
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int WAIT_MAX = WAIT_MAX_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic        halt,
    input  logic [15:0] exOut,
    input  logic [15:0] wrData,
    output logic        stall,
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic        err,
    output logic        halted,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic        mem_busy,
    input  logic        mem_done,
    input  logic [15:0] mem_rdata,
    input  logic        mem_err
);

    state_t      state;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] rdata_q;
    logic        write_q;

    logic idle_take;
    logic is_mem_op;
    logic accept;
    logic misaligned;
    logic pass_thru;
    logic wait_done;
    logic wait_timeout;

    // Instructions are only taken in IDLE and only while not halted.
    // A HALT is treated as a non-memory op even if memRead/memWrite are set.
    assign idle_take  = (state == ST_IDLE) && in_valid && !halted;
    assign is_mem_op  = (memRead || memWrite) && !halt;
    assign accept     = idle_take && is_mem_op && !is_misaligned(exOut);
    assign misaligned = idle_take && is_mem_op &&  is_misaligned(exOut);
    assign pass_thru  = idle_take && !is_mem_op;

    mem_req_fsm #(
        .WAIT_MAX (WAIT_MAX)
    ) u_fsm (
        .clk          (clk),
        .rst          (rst),
        .start        (accept),
        .op_write     (write_q),
        .mem_busy     (mem_busy),
        .mem_done     (mem_done),
        .state        (state),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .stall        (stall),
        .wait_done    (wait_done),
        .wait_timeout (wait_timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            write_q <= 1'b0;
            err     <= 1'b0;
            halted  <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= exOut;
                wdata_q <= wrData;
                write_q <= memWrite;
                rdata_q <= '0;          // stores and timeouts report 0
            end
            if (wait_done && !write_q) rdata_q <= mem_rdata;
            if (misaligned || wait_timeout || (wait_done && mem_err)) err <= 1'b1;
            if (idle_take && halt) halted <= 1'b1;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // NOTE: every output of this always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        out_valid = pass_thru || misaligned || (state == ST_DONE);
        out_data  = '0;
        if (pass_thru)
            out_data = exOut;
        else if (state == ST_DONE)
            out_data = rdata_q;
    end

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage
// Self-checking bench for mem_stage. The bench plays both the execute stage
// and the data memory; every expected value comes from the cycle schedule
// implied by each transaction's parameters (busy cycles, done latency,
// timeout limit) and a few sticky status bits.
// ---------------------------------------------------------------------------
module tb_mem_stage;

    localparam int WAIT_MAX = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, memRead, memWrite, halt;
    logic [15:0] exOut, wrData;
    logic        stall, out_valid, err, halted, mem_rd, mem_wr;
    logic [15:0] out_data, mem_addr, mem_wdata;
    logic        mem_busy, mem_done, mem_err;
    logic [15:0] mem_rdata;

    always #5 clk = ~clk;

    mem_stage #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .memRead   (memRead),
        .memWrite  (memWrite),
        .halt      (halt),
        .exOut     (exOut),
        .wrData    (wrData),
        .stall     (stall),
        .out_valid (out_valid),
        .out_data  (out_data),
        .err       (err),
        .halted    (halted),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_busy  (mem_busy),
        .mem_done  (mem_done),
        .mem_rdata (mem_rdata),
        .mem_err   (mem_err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit err_m    = 1'b0;
    bit halted_m = 1'b0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        memRead   = 1'b0;
        memWrite  = 1'b0;
        halt      = 1'b0;
        mem_busy  = 1'b0;
        mem_done  = 1'b0;
        mem_err   = 1'b0;
        mem_rdata = 16'($urandom);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".out_valid"}, out_valid, 1'b0);
        check({tag, ".stall"},     stall,     1'b0);
        check({tag, ".mem_rd"},    mem_rd,    1'b0);
        check({tag, ".mem_wr"},    mem_wr,    1'b0);
    endtask

    task automatic check_flags(input string tag);
        check({tag, ".err"},    err,    err_m);
        check({tag, ".halted"}, halted, halted_m);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        err_m    = 1'b0;
        halted_m = 1'b0;
        check_quiet("reset");
        check_flags("reset");
        check("reset.out_data",  out_data,  16'h0);
        check("reset.mem_addr",  mem_addr,  16'h0);
        check("reset.mem_wdata", mem_wdata, 16'h0);
        rst = 1'b0;
        tick();
    endtask

    task automatic pass_op(input logic [15:0] d);
        in_valid = 1'b1; memRead = 1'b0; memWrite = 1'b0; halt = 1'b0; exOut = d;
        #1;
        if (halted_m) check_quiet("pass_halted");
        else begin
            check("pass.out_valid", out_valid, 1'b1);
            check("pass.out_data",  out_data,  d);
            check("pass.stall",     stall,     1'b0);
            check("pass.mem_rd",    mem_rd,    1'b0);
        end
        check_flags("pass");
        tick();
        idle_inputs();
    endtask

    task automatic halt_op(input logic [15:0] d);
        in_valid = 1'b1; memRead = 1'b0; memWrite = 1'b0; halt = 1'b1; exOut = d;
        #1;
        if (halted_m) check_quiet("halt_again");
        else begin
            check("halt.out_valid", out_valid, 1'b1);
            check("halt.stall",     stall,     1'b0);
        end
        tick();
        halted_m = 1'b1;
        idle_inputs();
        #1;
        check_flags("after_halt");
    endtask

    task automatic misaligned_op(input bit w, input logic [15:0] a);
        in_valid = 1'b1; memRead = !w; memWrite = w; halt = 1'b0;
        exOut = a | 16'h0001; wrData = 16'($urandom);
        #1;
        if (halted_m) check_quiet("mis_halted");
        else begin
            check("mis.out_valid", out_valid, 1'b1);
            check("mis.out_data",  out_data,  16'h0);
            check("mis.stall",     stall,     1'b0);
            check("mis.mem_rd",    mem_rd,    1'b0);
            check("mis.mem_wr",    mem_wr,    1'b0);
        end
        tick();
        if (!halted_m) err_m = 1'b1;
        idle_inputs();
        #1;
        check_flags("after_mis");
        check_quiet("after_mis");
    endtask

    // Full load/store. done_n is the 1-based WAIT cycle carrying mem_done;
    // 0 or anything above WAIT_MAX means memory never answers.
    task automatic mem_op(input bit w, input logic [15:0] a, input logic [15:0] wd,
                          input int busy_n, input int done_n, input logic [15:0] rd,
                          input bit merr, input bit done_in_req);
        bit          timed_out;
        logic [15:0] exp_data;
        timed_out = !(done_n >= 1 && done_n <= WAIT_MAX);

        in_valid = 1'b1; memRead = !w; memWrite = w; halt = 1'b0;
        exOut = a & 16'hFFFE; wrData = wd;
        #1;
        if (halted_m) begin
            check_quiet("memop_halted");
            tick();
            idle_inputs();
            #1;
            check_quiet("memop_halted_next");
            return;
        end
        check("accept.stall",     stall,     1'b1);
        check("accept.out_valid", out_valid, 1'b0);
        check("accept.mem_rd",    mem_rd,    1'b0);
        check("accept.mem_wr",    mem_wr,    1'b0);
        tick();

        // Request phase: held while busy, exactly one non-busy cycle.
        for (int i = 0; i <= busy_n; i++) begin
            mem_busy  = (i < busy_n);
            mem_done  = done_in_req;
            mem_err   = done_in_req;
            mem_rdata = 16'($urandom);
            #1;
            check("req.mem_rd",    mem_rd,    !w);
            check("req.mem_wr",    mem_wr,    w);
            check("req.mem_addr",  mem_addr,  a & 16'hFFFE);
            check("req.mem_wdata", mem_wdata, wd);
            check("req.stall",     stall,     1'b1);
            check("req.out_valid", out_valid, 1'b0);
            tick();
        end
        mem_busy = 1'b0;

        // Wait phase: stall held until mem_done or the timeout limit.
        for (int k = 1; k <= WAIT_MAX; k++) begin
            mem_done  = (k == done_n);
            mem_err   = (k == done_n) ? merr : 1'($urandom_range(0, 1));
            mem_rdata = (k == done_n) ? rd : 16'($urandom);
            #1;
            check("wait.stall",     stall,     1'b1);
            check("wait.mem_rd",    mem_rd,    1'b0);
            check("wait.mem_wr",    mem_wr,    1'b0);
            check("wait.out_valid", out_valid, 1'b0);
            tick();
            if (k == done_n) break;
        end

        // Result cycle.
        idle_inputs();
        #1;
        exp_data = (!w && !timed_out) ? rd : 16'h0;
        if (timed_out || merr) err_m = 1'b1;
        check("done.out_valid", out_valid, 1'b1);
        check("done.out_data",  out_data,  exp_data);
        check("done.stall",     stall,     1'b0);
        check("done.mem_rd",    mem_rd,    1'b0);
        check_flags("done");
        tick();
        #1;
        check_quiet("post_done");
    endtask

    initial begin
        idle_inputs();
        exOut  = '0;
        wrData = '0;
        rst    = 1'b1;
        tick();
        do_reset();

        // Directed cases.
        pass_op(16'h1234);
        mem_op(1'b0, 16'h0040, 16'h0000, 0, 2, 16'hBEEF, 1'b0, 1'b0);
        mem_op(1'b1, 16'h0010, 16'h00AA, 3, 1, 16'h0000, 1'b0, 1'b0);
        mem_op(1'b0, 16'h0022, 16'h0000, 1, WAIT_MAX, 16'hC0DE, 1'b0, 1'b1);
        mem_op(1'b0, 16'h0042, 16'h0000, 0, 3, 16'h5A5A, 1'b1, 1'b0);
        do_reset();
        misaligned_op(1'b0, 16'h0003);
        pass_op(16'hA5A5);
        do_reset();
        mem_op(1'b0, 16'h0080, 16'h0000, 0, 0, 16'h1111, 1'b0, 1'b0);

        // Reset during WAIT, then a stray mem_done must be ignored.
        do_reset();
        in_valid = 1'b1; memRead = 1'b1; exOut = 16'h0100;
        tick();
        tick();
        tick();
        tick();
        idle_inputs();
        rst = 1'b1;
        tick();
        err_m = 1'b0;
        check_quiet("rst_mid");
        rst = 1'b0;
        mem_done = 1'b1; mem_err = 1'b1; mem_rdata = 16'hDEAD;
        tick();
        check_quiet("stray_done");
        check_flags("stray_done");
        idle_inputs();
        tick();
        check_quiet("stray_done_next");
        check_flags("stray_done_next");

        // Halt blocks all further work.
        halt_op(16'h0F0F);
        mem_op(1'b0, 16'h0040, 16'h0000, 0, 2, 16'hBEEF, 1'b0, 1'b0);
        pass_op(16'h7777);
        do_reset();

        // Randomized traffic.
        for (int n = 0; n < 80; n++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind <= 2)
                pass_op(16'($urandom));
            else if (kind == 3)
                misaligned_op(1'($urandom_range(0, 1)), 16'($urandom));
            else if (kind == 9 && n > 70)
                halt_op(16'($urandom));
            else
                mem_op(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                       $urandom_range(0, 3), $urandom_range(0, WAIT_MAX + 2),
                       16'($urandom), ($urandom_range(0, 7) == 0),
                       1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
